// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the byte-serial memory arbiter: FSM state
//   encodings, data_size codes, the IO window base address and byte-lane
//   helper functions used by the arbiter and its lane mux.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Start of the memory-mapped IO window (mem_a[17:16] = 11).
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  // Number of bus bytes moved for a data_size code; the reserved code 11
  // behaves like a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Little-endian byte lane extraction: lane 0 is bits [7:0].
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    get_byte = word[7:0];
      2'd1:    get_byte = word[15:8];
      2'd2:    get_byte = word[23:16];
      default: get_byte = word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_lane_mux.sv
// mem_arbiter_lane_mux
//   Combinational byte-lane steering for the arbiter.
//   Ports:
//     rbuf   in  32  partially assembled read word
//     rbyte  in  8   byte arriving from the bus
//     rlane  in  2   lane the arriving byte belongs to
//     wdata  in  32  latched store word
//     wlane  in  2   lane of the byte currently being written
//     merged out 32  rbuf with rbyte placed into lane rlane
//     wbyte  out 8   store byte for lane wlane
module mem_arbiter_lane_mux
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] rbuf,
  input  logic [7:0]  rbyte,
  input  logic [1:0]  rlane,
  input  logic [31:0] wdata,
  input  logic [1:0]  wlane,
  output logic [31:0] merged,
  output logic [7:0]  wbyte
);

  // Insert the incoming byte into its lane, keeping the other lanes.
  always_comb begin
    merged = rbuf;
    case (rlane)
      2'd0:    merged[7:0]   = rbyte;
      2'd1:    merged[15:8]  = rbyte;
      2'd2:    merged[23:16] = rbyte;
      default: merged[31:24] = rbyte;
    endcase
  end

  assign wbyte = get_byte(wdata, wlane);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Byte-serial memory controller between the CPU pipeline and the 8-bit
//   RAM/IO bus. Serves the instruction fetch port (always 4 bytes) and the
//   data port (1/2/4-byte loads and stores); the data port has priority.
//   Words are assembled/split little-endian.
//   Ports:
//     clk, rst                         clock, async active-high reset
//     rdy                              low = pause, nothing advances
//     inst_req/inst_addr/inst_cancel   fetch request, address, flush
//     inst_valid/inst_data/inst_addr_o fetch result pulse, word, address
//     data_req/data_we/data_size       load/store request, kind, size
//     data_addr/data_wdata             load/store address and store data
//     data_valid/data_rdata            completion pulse, zero-extended load
//     mem_din                          RAM byte, one cycle after address
//     mem_dout/mem_a/mem_wr            RAM write byte, address, write enable
//     busy                             FSM not idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic              busy
);

  state_t            state;
  logic              src_inst;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        len_q;
  logic [2:0]        issue_idx;
  logic [2:0]        recv_idx;
  logic              pend;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] inst_data_q;
  logic [ADDR_W-1:0] inst_addr_q;
  logic [DATA_W-1:0] data_rdata_q;

  logic [DATA_W-1:0] merged;
  logic [7:0]        wbyte;
  logic              cancel_hit;

  mem_arbiter_lane_mux u_lane_mux (
    .rbuf   (rbuf),
    .rbyte  (mem_din),
    .rlane  (recv_idx[1:0]),
    .wdata  (wdata_q),
    .wlane  (issue_idx[1:0]),
    .merged (merged),
    .wbyte  (wbyte)
  );

  assign cancel_hit = src_inst && inst_cancel;

  // Main FSM. issue_idx counts addresses put on the bus, recv_idx counts
  // bytes captured; pend marks that the byte for the previous address is
  // on mem_din this cycle. During a read stall the bus re-presents the
  // oldest uncaptured address, so once rdy returns that byte is already
  // on mem_din and issuing resumes right behind it: the stall costs
  // exactly its own length. Stores simply freeze, so every byte is
  // written exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      src_inst     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      len_q        <= 3'd0;
      issue_idx    <= 3'd0;
      recv_idx     <= 3'd0;
      pend         <= 1'b0;
      rbuf         <= '0;
      inst_data_q  <= '0;
      inst_addr_q  <= '0;
      data_rdata_q <= '0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (data_req) begin
            src_inst  <= 1'b0;
            addr_q    <= data_addr;
            wdata_q   <= data_wdata;
            len_q     <= size_bytes(data_size);
            issue_idx <= 3'd0;
            recv_idx  <= 3'd0;
            pend      <= 1'b0;
            rbuf      <= '0;
            state     <= data_we ? S_WR : S_RD;
          end else if (inst_req && !inst_cancel) begin
            src_inst    <= 1'b1;
            addr_q      <= inst_addr;
            inst_addr_q <= inst_addr;
            len_q       <= 3'd4;
            issue_idx   <= 3'd0;
            recv_idx    <= 3'd0;
            pend        <= 1'b0;
            rbuf        <= '0;
            state       <= S_RD;
          end
        end
        S_RD: begin
          if (cancel_hit) begin
            pend  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (pend) begin
              rbuf     <= merged;
              recv_idx <= recv_idx + 3'd1;
              if (recv_idx == len_q - 3'd1) begin
                state <= S_DONE;
                if (src_inst) begin
                  inst_data_q <= merged;
                end else begin
                  data_rdata_q <= merged;
                end
              end
            end
            if (issue_idx < len_q) begin
              issue_idx <= issue_idx + 3'd1;
              pend      <= 1'b1;
            end else begin
              pend <= 1'b0;
            end
          end
        end
        S_WR: begin
          issue_idx <= issue_idx + 3'd1;
          if (issue_idx == len_q - 3'd1) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end else if (state == S_RD) begin
      issue_idx <= recv_idx + 3'd1;
      pend      <= 1'b1;
    end
  end

  // Bus drive. Outside RD/WR the bus sits at zero. While stalled in RD the
  // address of the oldest uncaptured byte is shown; writes are suppressed
  // whenever rdy is low.
  always_comb begin
    mem_a    = '0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    if (state == S_RD) begin
      if (!rdy) begin
        mem_a = addr_q + {{(ADDR_W-3){1'b0}}, recv_idx};
      end else if (issue_idx < len_q) begin
        mem_a = addr_q + {{(ADDR_W-3){1'b0}}, issue_idx};
      end
    end else if (state == S_WR) begin
      mem_a    = addr_q + {{(ADDR_W-3){1'b0}}, issue_idx};
      mem_dout = wbyte;
      mem_wr   = rdy;
    end
  end

  // The completion pulse is gated by rdy so a stalled DONE still produces a
  // single pulse, and by inst_cancel so a flushed fetch never reports.
  assign inst_valid  = (state == S_DONE) && rdy && src_inst && !inst_cancel;
  assign data_valid  = (state == S_DONE) && rdy && !src_inst;
  assign inst_data   = inst_data_q;
  assign inst_addr_o = inst_addr_q;
  assign data_rdata  = data_rdata_q;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a byte RAM model on the bus, a
//   scoreboard of expected completions popped on every valid pulse, and
//   one task per scenario checking bus timing against the cycle of accept.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_addr_o;
  logic        data_req;
  logic        data_we;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int io_reads = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    bit          is_store;
  } exp_t;

  exp_t        inst_q[$];
  exp_t        data_q[$];
  logic [31:0] wr_log[$];

  logic [7:0]  ram [0:262143];

  logic [31:0] tr_a    [0:63];
  logic [7:0]  tr_dout [0:63];
  bit          tr_wr   [0:63];
  bit          tr_busy [0:63];

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_cancel (inst_cancel),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_addr_o (inst_addr_o),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_valid  (data_valid),
    .data_rdata  (data_rdata),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_a       (mem_a),
    .mem_wr      (mem_wr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // RAM model: registered read data, write on the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  // Bus monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_wr) wr_log.push_back(mem_a);
      if (busy && !mem_wr && rdy && mem_a == IO_BASE) io_reads++;
      if (inst_valid) begin
        checks++;
        if (inst_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL inst_valid_unexpected got pulse addr=%h data=%h required no pulse", inst_addr_o, inst_data);
        end else begin
          e = inst_q.pop_front();
          if (inst_data !== e.data || inst_addr_o !== e.addr) begin
            errors++;
            $display("[TB] FAIL inst_result got data=%h addr=%h required data=%h addr=%h", inst_data, inst_addr_o, e.data, e.addr);
          end
        end
      end
      if (data_valid) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL data_valid_unexpected got pulse rdata=%h required no pulse", data_rdata);
        end else begin
          e = data_q.pop_front();
          if (!e.is_store && data_rdata !== e.data) begin
            errors++;
            $display("[TB] FAIL data_rdata got %h required %h", data_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish required finish before time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_trace();
    for (int i = 0; i < 64; i++) begin
      tr_a[i] = '0;
      tr_dout[i] = '0;
      tr_wr[i] = 1'b0;
      tr_busy[i] = 1'b0;
    end
  endtask

  // Records bus activity per cycle relative to t0 until the chosen valid
  // pulse is seen; vrel is -1 if it never arrives within the budget.
  task automatic trace_until(input int t0, input bit want_inst, output int vrel);
    int rel;
    vrel = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel >= 0 && rel < 64) begin
        tr_a[rel] = mem_a;
        tr_dout[rel] = mem_dout;
        tr_wr[rel] = mem_wr;
        tr_busy[rel] = busy;
      end
      if (want_inst ? inst_valid : data_valid) begin
        vrel = rel;
        break;
      end
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [17:0] a);
    ram_word = {ram[a + 18'd3], ram[a + 18'd2], ram[a + 18'd1], ram[a]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    inst_req = 1'b0;
    inst_addr = '0;
    inst_cancel = 1'b0;
    data_req = 1'b0;
    data_we = 1'b0;
    data_size = 2'b00;
    data_addr = '0;
    data_wdata = '0;
    #2;
    checks++;
    if ({mem_a, mem_dout, mem_wr, busy, inst_valid, data_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus got a=%h dout=%h wr=%b busy=%b iv=%b dv=%b required all 0", mem_a, mem_dout, mem_wr, busy, inst_valid, data_valid);
    end
    checks++;
    if ({inst_data, inst_addr_o, data_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got idata=%h iaddr=%h rdata=%h required 0", inst_data, inst_addr_o, data_rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fetch();
    int t0, v;
    ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h00;
    clear_trace();
    inst_q.push_back('{32'h0000_0013, 32'h0, 1'b0});
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h0; t0 = cyc;
    trace_until(t0, 1'b1, v);
    @(posedge clk); #1 inst_req = 1'b0;
    checks++;
    if (v !== 6) begin
      errors++;
      $display("[TB] FAIL fetch_latency got %0d required 6", v);
    end
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (tr_a[j] !== 32'(j - 1) || tr_wr[j] !== 1'b0 || tr_busy[j] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fetch_addr_%0d got a=%h wr=%b busy=%b required a=%h wr=0 busy=1", j, tr_a[j], tr_wr[j], tr_busy[j], j - 1);
      end
    end
  endtask

  task automatic test_store();
    int t0, v;
    logic [31:0] w;
    logic [7:0] eb;
    w = 32'hDEAD_BEEF;
    clear_trace();
    data_q.push_back('{32'h0, 32'h1000, 1'b1});
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_size = SZ_W; data_addr = 32'h1000; data_wdata = w; t0 = cyc;
    trace_until(t0, 1'b0, v);
    @(posedge clk); #1 data_req = 1'b0; data_we = 1'b0;
    checks++;
    if (v !== 5) begin
      errors++;
      $display("[TB] FAIL store_latency got %0d required 5", v);
    end
    for (int j = 1; j <= 4; j++) begin
      eb = w[8*(j-1) +: 8];
      checks++;
      if (tr_wr[j] !== 1'b1 || tr_a[j] !== 32'h1000 + 32'(j - 1) || tr_dout[j] !== eb) begin
        errors++;
        $display("[TB] FAIL store_byte_%0d got wr=%b a=%h dout=%h required wr=1 a=%h dout=%h", j, tr_wr[j], tr_a[j], tr_dout[j], 32'h1000 + 32'(j - 1), eb);
      end
    end
    checks++;
    if (tr_wr[5] !== 1'b0 || ram_word(18'h1000) !== w) begin
      errors++;
      $display("[TB] FAIL store_ram got wr5=%b word=%h required wr5=0 word=%h", tr_wr[5], ram_word(18'h1000), w);
    end
  endtask

  task automatic test_priority();
    int t0, vd, vi, io_before;
    ram[IO_BASE[17:0]] = 8'hA5;
    for (int i = 0; i < 4; i++) ram[18'h20 + 18'(i)] = 8'($urandom);
    clear_trace();
    data_q.push_back('{32'h0000_00A5, 32'h0, 1'b0});
    inst_q.push_back('{ram_word(18'h20), 32'h20, 1'b0});
    io_before = io_reads;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h20;
    data_req = 1'b1; data_we = 1'b0; data_size = SZ_B; data_addr = IO_BASE;
    t0 = cyc;
    trace_until(t0, 1'b0, vd);
    @(posedge clk); #1 data_req = 1'b0;
    trace_until(t0, 1'b1, vi);
    @(posedge clk); #1 inst_req = 1'b0;
    checks++;
    if (vd !== 3 || tr_a[1] !== IO_BASE) begin
      errors++;
      $display("[TB] FAIL prio_data got valid@%0d a1=%h required valid@3 a1=%h", vd, tr_a[1], IO_BASE);
    end
    checks++;
    if (vi !== 10 || tr_a[5] !== 32'h20 || tr_busy[4] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_inst got valid@%0d a5=%h busy4=%b required valid@10 a5=00000020 busy4=0", vi, tr_a[5], tr_busy[4]);
    end
    checks++;
    if (io_reads - io_before !== 1) begin
      errors++;
      $display("[TB] FAIL prio_io_reads got %0d required 1", io_reads - io_before);
    end
  endtask

  task automatic test_cancel();
    int t0, t1, v;
    for (int i = 0; i < 4; i++) begin
      ram[18'h40 + 18'(i)] = 8'($urandom);
      ram[18'h80 + 18'(i)] = 8'($urandom);
    end
    clear_trace();
    inst_q.push_back('{ram_word(18'h80), 32'h80, 1'b0});
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h40; t0 = cyc;
    repeat (3) @(posedge clk);
    #1 inst_cancel = 1'b1;
    @(posedge clk); #1;
    inst_cancel = 1'b0; inst_addr = 32'h80; t1 = cyc;
    trace_until(t1, 1'b1, v);
    @(posedge clk); #1 inst_req = 1'b0;
    checks++;
    if (t1 - t0 !== 4 || tr_busy[0] !== 1'b0 || tr_a[1] !== 32'h80) begin
      errors++;
      $display("[TB] FAIL cancel_restart got dt=%0d busy=%b a1=%h required dt=4 busy=0 a1=00000080", t1 - t0, tr_busy[0], tr_a[1]);
    end
    checks++;
    if (v !== 6) begin
      errors++;
      $display("[TB] FAIL cancel_refetch_latency got %0d required 6", v);
    end
  endtask

  task automatic test_stall_load();
    int t0, v;
    for (int i = 0; i < 4; i++) ram[18'h2000 + 18'(i)] = 8'($urandom_range(128, 255));
    clear_trace();
    data_q.push_back('{ram_word(18'h2000), 32'h2000, 1'b0});
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_size = SZ_W; data_addr = 32'h2000; t0 = cyc;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
      end
      trace_until(t0, 1'b0, v);
    join
    @(posedge clk); #1 data_req = 1'b0;
    checks++;
    if (v !== 8) begin
      errors++;
      $display("[TB] FAIL stall_load_latency got %0d required 8", v);
    end
    checks++;
    if (tr_a[4] !== 32'h2001 || tr_a[6] !== 32'h2003) begin
      errors++;
      $display("[TB] FAIL stall_load_addr got a4=%h a6=%h required a4=00002001 a6=00002003", tr_a[4], tr_a[6]);
    end
  endtask

  task automatic test_stall_store();
    int t0, v, base, cnt;
    logic [31:0] w;
    w = $urandom;
    base = wr_log.size();
    clear_trace();
    data_q.push_back('{32'h0, 32'h3000, 1'b1});
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_size = SZ_W; data_addr = 32'h3000; data_wdata = w; t0 = cyc;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
      end
      trace_until(t0, 1'b0, v);
    join
    @(posedge clk); #1 data_req = 1'b0; data_we = 1'b0;
    checks++;
    if (v !== 7 || tr_wr[2] !== 1'b0 || tr_wr[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_store got valid@%0d wr2=%b wr3=%b required valid@7 wr2=0 wr3=0", v, tr_wr[2], tr_wr[3]);
    end
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      for (int k = base; k < wr_log.size(); k++)
        if (wr_log[k] == 32'h3000 + 32'(i)) cnt++;
      checks++;
      if (cnt !== 1 || ram[18'h3000 + 18'(i)] !== w[8*i +: 8]) begin
        errors++;
        $display("[TB] FAIL stall_store_byte_%0d got writes=%0d byte=%h required writes=1 byte=%h", i, cnt, ram[18'h3000 + 18'(i)], w[8*i +: 8]);
      end
    end
    checks++;
    if (wr_log.size() - base !== 4) begin
      errors++;
      $display("[TB] FAIL stall_store_total got %0d writes required 4", wr_log.size() - base);
    end
  endtask

  task automatic test_wrap();
    int t0, v;
    ram[18'h3FFFF] = 8'hC7;
    ram[0] = 8'h9E;
    clear_trace();
    data_q.push_back('{{16'h0, ram[0], ram[18'h3FFFF]}, 32'h0, 1'b0});
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_size = SZ_H; data_addr = 32'hFFFF_FFFF; t0 = cyc;
    trace_until(t0, 1'b0, v);
    @(posedge clk); #1 data_req = 1'b0;
    checks++;
    if (v !== 4 || tr_a[1] !== 32'hFFFF_FFFF || tr_a[2] !== 32'h0 || tr_busy[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_half got valid@%0d a1=%h a2=%h required valid@4 a1=ffffffff a2=00000000", v, tr_a[1], tr_a[2]);
    end
  endtask

  task automatic test_reset_mid();
    int t0, v;
    for (int i = 0; i < 4; i++) ram[18'h4000 + 18'(i)] = 8'h00;
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_size = SZ_W; data_addr = 32'h4000; data_wdata = 32'h1122_3344; t0 = cyc;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h4002 || mem_dout !== 8'h22) begin
      errors++;
      $display("[TB] FAIL rstmid_pre got wr=%b a=%h dout=%h required wr=1 a=00004002 dout=22", mem_wr, mem_a, mem_dout);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_async got wr=%b a=%h busy=%b required all 0", mem_wr, mem_a, busy);
    end
    data_req = 1'b0; data_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (ram[18'h4000] !== 8'h44 || ram[18'h4001] !== 8'h33 || ram[18'h4002] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rstmid_partial got %h %h %h required 44 33 00", ram[18'h4000], ram[18'h4001], ram[18'h4002]);
    end
    clear_trace();
    data_q.push_back('{32'h0000_0033, 32'h0, 1'b0});
    @(posedge clk); #1;
    data_req = 1'b1; data_size = SZ_B; data_addr = 32'h4001; t0 = cyc;
    trace_until(t0, 1'b0, v);
    @(posedge clk); #1 data_req = 1'b0;
    checks++;
    if (v !== 3) begin
      errors++;
      $display("[TB] FAIL rstmid_fresh_latency got %0d required 3", v);
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_cancel();
    test_stall_load();
    test_stall_store();
    test_wrap();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (inst_q.size() !== 0 || data_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got inst=%0d data=%0d pending required 0", inst_q.size(), data_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
